// File: rtl/bicubic_channel_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bicubic_channel_sched_if                                     |
// | Description : Window input, bicubic core request/response and output beat  |
// |               signals of the channel scheduler, bundled for port reuse.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface bicubic_channel_sched_if #(
  parameter int CHANNEL_WIDTH = 8
);
  localparam int c_PX_W = 3 * CHANNEL_WIDTH;

  // Upstream window from the line buffer
  logic                         in_valid;
  logic                         in_ready;
  logic [16*c_PX_W-1:0]         in_win;
  // Request/response towards the shared bicubic core
  logic                         core_req_valid;
  logic                         core_req_ready;
  logic [16*CHANNEL_WIDTH-1:0]  core_p;
  logic                         core_rsp_valid;
  logic                         core_rsp_ready;
  logic [8*CHANNEL_WIDTH-1:0]   core_rsp_data;
  // Downstream beats to the output packer
  logic                         out_valid;
  logic                         out_ready;
  logic [8*c_PX_W-1:0]          out_data;
  logic                         out_last;

  // Scheduler side
  modport slave (
    input  in_valid, in_win, core_req_ready, core_rsp_valid, core_rsp_data, out_ready,
    output in_ready, core_req_valid, core_p, core_rsp_ready, out_valid, out_data, out_last
  );

  // Surrounding system side (line buffer, core, packer)
  modport master (
    output in_valid, in_win, core_req_ready, core_rsp_valid, core_rsp_data, out_ready,
    input  in_ready, core_req_valid, core_p, core_rsp_ready, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/bicubic_channel_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bicubic_channel_sched                                        |
// | Description : Shares one bicubic_upsample_2 core across the R/G/B channels |
// |               of a 4x4 window: six core steps (channel x half), then the   |
// |               4x4 upsampled RGB block leaves as two 8-pixel beats.         |
// |               Optional statistics counters: define BCCI_SCHED_STAT_EN.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bicubic_channel_sched #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  bicubic_channel_sched_if.slave     bus,
  output logic [CNT_WIDTH-1:0]       stat_windows,
  output logic [CNT_WIDTH-1:0]       stat_stalls
);
  localparam int c_CW = CHANNEL_WIDTH;
  localparam int c_PW = 3 * CHANNEL_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OUT0 = 2'd2,
    S_OUT1 = 2'd3
  } state_t;

  state_t                 r_state;
  logic [16*c_PW-1:0]     r_win;
  // Result block, pixel index = row*4 + col, channel lanes as in in_win
  logic [c_PW-1:0]        r_blk [16];
  logic [1:0]             r_ch;
  logic                   r_half;
  logic                   r_in_ready;
  logic                   r_core_req_valid;
  logic                   r_core_rsp_ready;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic [8*c_PW-1:0]      r_out_data;

  logic [16*c_CW-1:0]     w_core_p;
  logic [8*c_PW-1:0]      w_beat0;
  logic [8*c_PW-1:0]      w_beat1;
  logic                   w_in_hs;
  logic                   w_step;
  logic                   w_out_hs;

  assign w_in_hs  = bus.in_valid & r_in_ready;
  assign w_step   = bus.core_rsp_valid & r_core_rsp_ready;
  assign w_out_hs = r_out_valid & bus.out_ready;

  // Channel ch of every captured pixel feeds the core; R is the top lane
  for (genvar k = 0; k < 16; k++) begin : g_core_p
    assign w_core_p[k*c_CW +: c_CW] =
      (r_ch == 2'd1) ? r_win[k*c_PW + c_CW   +: c_CW] :
      (r_ch == 2'd2) ? r_win[k*c_PW          +: c_CW] :
                       r_win[k*c_PW + 2*c_CW +: c_CW];
  end

  // Beat 0 carries rows U1/U2 (pixels 0..7), beat 1 rows U3/U4 (pixels 8..15)
  for (genvar j = 0; j < 8; j++) begin : g_beat
    assign w_beat0[j*c_PW +: c_PW] = r_blk[j];
    assign w_beat1[j*c_PW +: c_PW] = r_blk[j+8];
  end

  // Window sequencing: capture, six core steps, two output beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_in_ready       <= 1'b1;
      r_core_req_valid <= 1'b0;
      r_core_rsp_ready <= 1'b0;
      r_out_valid      <= 1'b0;
      r_out_last       <= 1'b0;
      r_out_data       <= '0;
      r_win            <= '0;
      r_ch             <= 2'd0;
      r_half           <= 1'b0;
      for (int i = 0; i < 16; i++) r_blk[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_hs) begin
            r_win            <= bus.in_win;
            r_in_ready       <= 1'b0;
            r_core_req_valid <= 1'b1;
            r_core_rsp_ready <= 1'b1;
            r_state          <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_step) begin
            // Half h: data1..8 land on block pixels 8h..8h+7 (rows 2h, 2h+1)
            for (int j = 0; j < 8; j++) begin
              case (r_ch)
                2'd1:    r_blk[{r_half, 3'(j)}][c_CW +: c_CW]   <= bus.core_rsp_data[j*c_CW +: c_CW];
                2'd2:    r_blk[{r_half, 3'(j)}][0 +: c_CW]      <= bus.core_rsp_data[j*c_CW +: c_CW];
                default: r_blk[{r_half, 3'(j)}][2*c_CW +: c_CW] <= bus.core_rsp_data[j*c_CW +: c_CW];
              endcase
            end
            r_half <= ~r_half;
            if (r_half) begin
              if (r_ch == 2'd2) begin
                // Rows U1/U2 of all channels are complete before the last step
                r_ch             <= 2'd0;
                r_core_req_valid <= 1'b0;
                r_core_rsp_ready <= 1'b0;
                r_out_valid      <= 1'b1;
                r_out_last       <= 1'b0;
                r_out_data       <= w_beat0;
                r_state          <= S_OUT0;
              end else begin
                r_ch <= r_ch + 2'd1;
              end
            end
          end
        end
        S_OUT0: begin
          if (w_out_hs) begin
            r_out_last <= 1'b1;
            r_out_data <= w_beat1;
            r_state    <= S_OUT1;
          end
        end
        S_OUT1: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.core_req_valid = r_core_req_valid;
  assign bus.core_rsp_ready = r_core_rsp_ready;
  assign bus.core_p         = w_core_p;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_last       = r_out_last;
  assign bus.out_data       = r_out_data;

  // Core must sit in S1 (req_ready high) for half 0 and be busy for half 1
  a_core_sync: assert property (@(posedge clk) disable iff (!rst_n)
    w_step |-> (bus.core_req_ready == ~r_half));

`ifdef BCCI_SCHED_STAT_EN
  logic [CNT_WIDTH-1:0] r_stat_windows;
  logic [CNT_WIDTH-1:0] r_stat_stalls;

  // Saturating counts of finished windows and back-pressured output cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_windows <= '0;
      r_stat_stalls  <= '0;
    end else begin
      if ((r_state == S_OUT1) && w_out_hs && !(&r_stat_windows))
        r_stat_windows <= r_stat_windows + 1'b1;
      if (r_out_valid && !bus.out_ready && !(&r_stat_stalls))
        r_stat_stalls <= r_stat_stalls + 1'b1;
    end
  end

  assign stat_windows = r_stat_windows;
  assign stat_stalls  = r_stat_stalls;
`else
  assign stat_windows = '0;
  assign stat_stalls  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bicubic_channel_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bicubic_channel_sched                                     |
// | Description : Scoreboard bench for bicubic_channel_sched with a stand-in   |
// |               two-phase core and a per-window block reference model.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_bicubic_channel_sched;
  localparam int CW    = 8;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef BCCI_SCHED_STAT_EN
  localparam bit STAT_ON = 1'b1;
`else
  localparam bit STAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] stat_windows;
  logic [CNT_W-1:0] stat_stalls;

  bicubic_channel_sched_if #(.CHANNEL_WIDTH(CW)) bus();

  bicubic_channel_sched #(.CHANNEL_WIDTH(CW), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .stat_windows(stat_windows), .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_w(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Stand-in core: upsampled pixel i of the 4x4 block = rounded mean of two taps
  function automatic logic [7:0] interp(input logic [127:0] p, input int i);
    int a, b;
    a = int'(p[8*i +: 8]);
    b = int'(p[8*((5*i + 3) % 16) +: 8]);
    return 8'((a + b + 1) / 2);
  endfunction

  // Reference: whole 4x4 RGB block, pixel i = row i/4, col i%4, per channel
  function automatic logic [383:0] ref_block(input logic [383:0] win);
    logic [383:0] r;
    logic [127:0] chn;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 16; k++) chn[8*k +: 8] = win[24*k + 8*(2-c) +: 8];
      for (int i = 0; i < 16; i++) r[24*i + 8*(2-c) +: 8] = interp(chn, i);
    end
    return r;
  endfunction

  // Core model: phase 0 expects a new request (S1), phase 1 returns the lower half
  logic core_s;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) core_s <= 1'b0;
    else if (bus.core_rsp_valid && bus.core_rsp_ready) core_s <= ~core_s;

  assign bus.core_req_ready = ~core_s;

  always_comb begin
    bus.core_rsp_data = '0;
    for (int j = 0; j < 8; j++)
      bus.core_rsp_data[8*j +: 8] = interp(bus.core_p, (core_s ? 8 : 0) + j);
  end

  bit rsp_rand = 1'b0;
  bit out_rand = 1'b0;
  bit lat_chk  = 1'b0;
  bit b2b_chk  = 1'b0;
  int last_acc = -1;

  initial forever begin
    @(posedge clk); #1;
    bus.core_rsp_valid = rsp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial forever begin
    @(posedge clk); #1;
    if (out_rand) bus.out_ready = ($urandom_range(0, 2) != 0);
  end

  // Scoreboard state
  logic [191:0] exp_data_q[$];
  bit           exp_last_q[$];
  int           acc_cyc_q[$];
  bit           seen0 = 1'b0;
  int           m_win = 0;
  int           m_stall = 0;
  logic [383:0] mon_blk;
  logic [191:0] mon_d;
  bit           mon_l;
  int           mon_t;

  // Stimulus side: every accepted window pushes its two expected beats
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready) begin
      mon_blk = ref_block(bus.in_win);
      exp_data_q.push_back(mon_blk[191:0]);   exp_last_q.push_back(1'b0);
      exp_data_q.push_back(mon_blk[383:192]); exp_last_q.push_back(1'b1);
      if (b2b_chk && last_acc >= 0) chk_i("accept_spacing", cyc + 1 - last_acc, 9);
      last_acc = cyc + 1;
      acc_cyc_q.push_back(cyc + 1);
    end
  end

  // Core protocol: a half-0 response must come with the request presented
  always @(negedge clk) begin
    if (rst_n && bus.core_rsp_valid && bus.core_rsp_ready && !core_s)
      chk_i("core_req_valid_h0", int'(bus.core_req_valid), 1);
  end

  // Output side: pop and compare every beat, track latency and statistics
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      chk_i("stat_windows", int'(stat_windows), STAT_ON ? m_win : 0);
      chk_i("stat_stalls", int'(stat_stalls), STAT_ON ? m_stall : 0);
      if (!seen0) begin
        seen0 = 1'b1;
        if (acc_cyc_q.size() != 0) begin
          mon_t = acc_cyc_q.pop_front();
          if (lat_chk) chk_i("beat0_latency", cyc + 1 - mon_t, 7);
        end
      end
      if (bus.out_ready) begin
        if (exp_data_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", bus.out_data);
        end else begin
          mon_d = exp_data_q.pop_front();
          mon_l = exp_last_q.pop_front();
          chk_w("out_data", bus.out_data, mon_d);
          chk_i("out_last", int'(bus.out_last), int'(mon_l));
        end
        if (bus.out_last) begin
          seen0 = 1'b0;
          if (m_win < SAT) m_win++;
        end
      end else begin
        if (m_stall < SAT) m_stall++;
      end
    end
  end

  function automatic logic [383:0] rand_win();
    logic [383:0] w;
    for (int i = 0; i < 12; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  task automatic send(input logic [383:0] w, input bit hold_valid);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_win   = w;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept");
    end
    if (!hold_valid) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_data_q.size() != 0 || bus.out_valid) && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_data_q.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_i({tag, "_in_ready"}, int'(bus.in_ready), 1);
    chk_i({tag, "_core_req_valid"}, int'(bus.core_req_valid), 0);
    chk_i({tag, "_core_rsp_ready"}, int'(bus.core_rsp_ready), 0);
    chk_i({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk_i({tag, "_out_last"}, int'(bus.out_last), 0);
    chk_w({tag, "_out_data"}, bus.out_data, 192'd0);
    chk_i({tag, "_stat_windows"}, int'(stat_windows), 0);
    chk_i({tag, "_stat_stalls"}, int'(stat_stalls), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  logic [383:0] win;
  logic [191:0] held;
  int steps;
  int n;

  initial begin
    bus.in_valid       = 1'b0;
    bus.in_win         = '0;
    bus.out_ready      = 1'b1;
    bus.core_rsp_valid = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Flat window: every output pixel equals the input colour
    lat_chk = 1'b1;
    for (int k = 0; k < 16; k++) win[24*k +: 24] = {8'd100, 8'd50, 8'd200};
    send(win, 1'b0);
    wait_drain();

    // Ramp in R only
    for (int k = 0; k < 16; k++) win[24*k +: 24] = {8'((k + 1) * 10), 8'd0, 8'd0};
    send(win, 1'b0);
    wait_drain();

    // Back-to-back windows with in_valid held high
    b2b_chk  = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 4; i++) send(rand_win(), 1'b1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    wait_drain();
    b2b_chk = 1'b0;

    // Five back-pressured cycles at the first beat
    bus.out_ready = 1'b0;
    send(rand_win(), 1'b0);
    n = 0;
    while (!bus.out_valid && n < 100) begin n++; @(negedge clk); end
    chk_i("stall_out_valid", int'(bus.out_valid), 1);
    held = bus.out_data;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk_w("stall_data_stable", bus.out_data, held);
      chk_i("stall_out_last", int'(bus.out_last), 0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_drain();

    // Reset while the third core step is pending
    send(rand_win(), 1'b0);
    steps = 0;
    n = 0;
    while (steps < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.core_rsp_valid && bus.core_rsp_ready) steps++;
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    exp_data_q.delete();
    exp_last_q.delete();
    acc_cyc_q.delete();
    seen0   = 1'b0;
    m_win   = 0;
    m_stall = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(rand_win(), 1'b0);
    wait_drain();

    // Randomised traffic: idle gaps, core response gaps, downstream back-pressure
    lat_chk  = 1'b0;
    rsp_rand = 1'b1;
    out_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(rand_win(), 1'b0);
    end
    wait_drain();
    out_rand = 1'b0;
    rsp_rand = 1'b0;
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk_i("final_stat_windows", int'(stat_windows), STAT_ON ? m_win : 0);
    chk_i("final_stat_stalls", int'(stat_stalls), STAT_ON ? m_stall : 0);
    chk_i("final_in_ready", int'(bus.in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
